// File: rtl/move_recorder.sv
// move_recorder: move stack that records the solver's current path and
// freezes it into ord when the solver signals done.
// Optional feature: define MOVE_CANCEL_EN to turn a push that reverses the
// top move into a pop, so immediate back-and-forth moves vanish.
// Move codes: UP=2'b00, DOWN=2'b01, RIGHT=2'b10, LEFT=2'b11; inverse pairs
// differ only in bit 0.
module move_recorder #(
  parameter int MAX_MOVES = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mv_push,
  input  logic                     mv_pop,
  input  logic [1:0]               mv_dir,
  input  logic                     done,
  output logic [4+2*MAX_MOVES-1:0] ord,
  output logic                     comp,
  output logic                     err,
  output logic                     busy
);

  localparam int SW = 2 * MAX_MOVES;
  localparam logic [3:0] MAX_D = 4'(MAX_MOVES);

  typedef enum logic [2:0] {
    IDLE,
    RECORD,
    FINAL,
    COMPLETE,
    ERROR
  } state_t;

  state_t          state_reg, state_next;
  logic [3:0]      depth_reg, depth_next;
  logic [SW-1:0]   slots_reg, slots_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic            comp_reg, comp_next;
  logic            err_reg, err_next;

  logic            do_push, do_pop, do_repl;
  logic            wr_en;
  logic [3:0]      wr_idx;
  logic [1:0]      wr_val;
  logic            fault;

`ifdef MOVE_CANCEL_EN
  logic [1:0]      top_dir;

  // Select the move currently on top of the stack (slot depth-1).
  always_comb begin
    top_dir = 2'b00;
    for (int i = 0; i < MAX_MOVES; i++) begin
      if (4'(i) == depth_reg - 4'd1) top_dir = slots_reg[2*i +: 2];
    end
  end
`endif

  // State and datapath registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      depth_reg <= 4'd0;
      slots_reg <= '0;
      cnt_reg   <= 4'd0;
      comp_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      depth_reg <= depth_next;
      slots_reg <= slots_next;
      cnt_reg   <= cnt_next;
      comp_reg  <= comp_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic: start overrides everything; RECORD edits the stack.
  always_comb begin
    state_next = state_reg;
    depth_next = depth_reg;
    slots_next = slots_reg;
    cnt_next   = cnt_reg;
    comp_next  = comp_reg;
    err_next   = err_reg;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_repl    = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = 4'd0;
    wr_val     = 2'b00;
    fault      = 1'b0;

    if (start) begin
      state_next = RECORD;
      depth_next = 4'd0;
      slots_next = '0;
      cnt_next   = 4'd0;
      comp_next  = 1'b0;
      err_next   = 1'b0;
    end else begin
      case (state_reg)
        RECORD: begin
          // Push+pop on an empty stack degrades to a plain push.
          do_repl = mv_push && mv_pop && (depth_reg != 4'd0);
          do_push = mv_push && (!mv_pop || (depth_reg == 4'd0));
          do_pop  = mv_pop && !mv_push;
`ifdef MOVE_CANCEL_EN
          if (do_push && !mv_pop && (depth_reg != 4'd0) &&
              (mv_dir == (top_dir ^ 2'b01))) begin
            do_push = 1'b0;
            do_pop  = 1'b1;
          end
`endif
          if (do_repl) begin
            wr_en  = 1'b1;
            wr_idx = depth_reg - 4'd1;
            wr_val = mv_dir;
          end else if (do_push) begin
            if (depth_reg < MAX_D) begin
              wr_en      = 1'b1;
              wr_idx     = depth_reg;
              wr_val     = mv_dir;
              depth_next = depth_reg + 4'd1;
            end else begin
              fault = 1'b1;
            end
          end else if (do_pop) begin
            if (depth_reg != 4'd0) begin
              wr_en      = 1'b1;
              wr_idx     = depth_reg - 4'd1;
              wr_val     = 2'b00;
              depth_next = depth_reg - 4'd1;
            end else begin
              fault = 1'b1;
            end
          end

          for (int i = 0; i < MAX_MOVES; i++) begin
            if (wr_en && (4'(i) == wr_idx)) slots_next[2*i +: 2] = wr_val;
          end

          if (fault) begin
            err_next   = 1'b1;
            state_next = ERROR;
          end else if (done) begin
            state_next = FINAL;
          end
        end
        FINAL: begin
          if (depth_reg == 4'd0) begin
            err_next   = 1'b1;
            state_next = ERROR;
          end else begin
            cnt_next   = depth_reg - 4'd1;
            comp_next  = 1'b1;
            state_next = COMPLETE;
          end
        end
        default: begin
          // IDLE, COMPLETE and ERROR hold until start.
        end
      endcase
    end
  end

  assign ord  = {cnt_reg, slots_reg};
  assign comp = comp_reg;
  assign err  = err_reg;
  assign busy = (state_reg == RECORD);

endmodule
